// File: rtl/hier_dispatch_pkg.sv
// hier_dispatch_pkg: shared state encoding and credit-width helper for the dispatch node
package hier_dispatch_pkg;
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_e;
    function automatic int cred_w(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction
endpackage

// File: rtl/hier_rr_arbiter.sv
// hier_rr_arbiter: combinational search for the first eligible channel at or after ptr
module hier_rr_arbiter #(
    parameter int NUM_CH = 5,
    parameter int PW = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [PW-1:0]     ptr,
    output logic [NUM_CH-1:0] grant_onehot,
    output logic [PW-1:0]     grant_idx,
    output logic              any
);
    logic [NUM_CH-1:0] rot;
    logic [PW:0]       sum;
    always_comb begin
        rot = NUM_CH'({eligible, eligible} >> ptr);
        any = |eligible;
        sum = '0;
        // descending scan so the lowest offset from ptr wins
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (rot[k]) sum = {1'b0, ptr} + (PW+1)'(k);
        grant_idx = sum >= (PW+1)'(NUM_CH) ? PW'(sum - (PW+1)'(NUM_CH)) : PW'(sum);
        for (int i = 0; i < NUM_CH; i++) grant_onehot[i] = any && grant_idx == PW'(i);
    end
endmodule

// File: rtl/hier_dispatch_node.sv
// hier_dispatch_node: credit-based round-robin job dispatcher to NUM_CH children
// Define HIER_DISPATCH_STATS_EN to add saturating per-child dispatch counters on ch_count.
module hier_dispatch_node
    import hier_dispatch_pkg::*;
#(
    parameter int NUM_CH    = 5,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic [NUM_CH-1:0]       ch_valid,
    input  logic [NUM_CH-1:0]       ch_ready,
    output logic [DATA_W-1:0]       ch_data,
    input  logic [NUM_CH-1:0]       ch_done,
    output logic                    idle,
    output logic                    err
`ifdef HIER_DISPATCH_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] ch_count
`endif
);
    localparam int CW = cred_w(MAX_OUTST);
    localparam int PW = $clog2(NUM_CH);
    localparam logic [CW-1:0] FULL = CW'(MAX_OUTST);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [NUM_CH-1:0] vld_q, vld_d;
    logic [PW-1:0]     gnt_q, gnt_d, rr_q, rr_d;
    logic [CW-1:0]     cred_q [NUM_CH];
    logic [CW-1:0]     cred_d [NUM_CH];
    logic              err_q, err_d;
    logic [NUM_CH-1:0] elig, arb_oh;
    logic [PW-1:0]     arb_idx;
    logic              arb_any, arb_en, fire, full_all;

    hier_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .eligible(elig),
        .ptr(rr_q),
        .grant_onehot(arb_oh),
        .grant_idx(arb_idx),
        .any(arb_any)
    );

    assign fire     = |(vld_q & ch_ready);
    // arbitrate in the accept cycle too, so ch_valid rises right after the parent transfer
    assign arb_en   = state_q == ST_IDLE ? in_valid : ~|vld_q;
    assign in_ready = state_q == ST_IDLE && !rst;
    assign idle     = in_ready && full_all;
    assign ch_valid = vld_q;
    assign ch_data  = hold_q;
    assign err      = err_q;

    always_comb begin
        full_all = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            elig[i]  = cred_q[i] != '0;
            full_all = full_all && cred_q[i] == FULL;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        vld_d   = vld_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        err_d   = err_q;
        cred_d  = cred_q;
        if (state_q == ST_IDLE && in_valid) begin
            state_d = ST_HOLD;
            hold_d  = in_data;
        end
        if (arb_en && arb_any) begin
            vld_d = arb_oh;
            gnt_d = arb_idx;
        end
        if (fire) begin
            vld_d   = '0;
            state_d = ST_IDLE;
            rr_d    = gnt_q == PW'(NUM_CH - 1) ? '0 : gnt_q + 1'b1;
        end
        // a done on a full child is only an error when no dispatch offsets it
        for (int i = 0; i < NUM_CH; i++)
            if (ch_done[i] && !(fire && gnt_q == PW'(i)) && cred_q[i] == FULL) err_d = 1'b1;
            else cred_d[i] = cred_q[i] + CW'(ch_done[i]) - CW'(fire && gnt_q == PW'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            vld_q   <= '0;
            gnt_q   <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) cred_q[i] <= FULL;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            vld_q   <= vld_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            cred_q  <= cred_d;
        end
    end

`ifdef HIER_DISPATCH_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (fire && gnt_q == PW'(i) && !(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + 1'b1;
        end
    end
    always_comb begin
        ch_count = '0;
        for (int i = 0; i < NUM_CH; i++) ch_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif
endmodule
